// File: rtl/mux51_pkg.sv
// Shared definitions for the 5:1 mux and its round-robin arbiter.
// Covers source encodings, arbiter state type and the modulo-5 step helper.
package mux51_pkg;

  localparam int NUM_SRC = 5;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_D = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Next source index with wrap e -> a; any out-of-range index also lands on a.
  function automatic logic [2:0] rr_next(input logic [2:0] idx);
    return (idx >= SEL_E) ? SEL_A : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker over five requesters.
// It scans ptr+1, ptr+2, ... modulo 5 and returns the first requesting source.
module rr_pick5
  import mux51_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] win,
  output logic       any
);

  always_comb begin
    logic [2:0] idx;
    win = SEL_A;
    any = 1'b0;
    idx = ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_next(idx);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux51_rr_arbiter.sv
// Round-robin arbiter driving the select of the 5:1 data mux.
// It holds a grant for up to max_burst beats, then forces one idle bubble before re-arbitrating.
module mux51_rr_arbiter
  import mux51_pkg::*;
#(
  parameter int max_burst = 4,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           req,
  output logic [2:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           ack,
  output arb_state_t           dbg_state,
  output logic [2:0]           dbg_ptr,
  output logic [cnt_width-1:0] dbg_cnt
);

  localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(max_burst - 1);

  arb_state_t           state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;

  logic [2:0] win;
  logic       any;
  logic       beat;

  rr_pick5 u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Handshake: a beat transfers in any cycle where out_valid and out_ready are both
  // high; the matching ack bit marks that beat as consumed from the granted source.
  always_comb begin
    out_valid = (state_q == GRANT) && req[sel_q];
    beat      = out_valid && out_ready;
    ack       = beat ? (5'b00001 << sel_q) : 5'b00000;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          sel_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q;
        end else if (beat && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          ptr_d   = sel_q;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ptr resets to e so that the first arbitration scan begins at a.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_A;
      ptr_q   <= SEL_E;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_mux51_rr_arbiter.sv
// Bench for mux51_rr_arbiter: two instances (max_burst 4 and 1) share stimulus.
// Each is checked against a source-level round-robin model, directed tables and corner sequences.
module tb_mux51_rr_arbiter;
  import mux51_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = 5'b0;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] sel4, sel1, ptr4, ptr1;
  logic       ov4, ov1;
  logic [4:0] ack4, ack1;
  logic [7:0] cnt4, cnt1;
  arb_state_t st4, st1;

  int n_vec = 0;
  int n_err = 0;

  mux51_rr_arbiter #(.max_burst(4), .cnt_width(8)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .sel(sel4), .out_valid(ov4), .out_ready(out_ready),
    .ack(ack4), .dbg_state(st4), .dbg_ptr(ptr4), .dbg_cnt(cnt4)
  );

  mux51_rr_arbiter #(.max_burst(1), .cnt_width(8)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .sel(sel1), .out_valid(ov1), .out_ready(out_ready),
    .ack(ack1), .dbg_state(st1), .dbg_ptr(ptr1), .dbg_cnt(cnt1)
  );

  // ---------------- reference model ----------------
  // Per instance: whether a source owns the mux, who, who owned it last, beats taken.
  int burst[2] = '{4, 1};
  bit m_busy[2];
  int m_owner[2];
  int m_last[2];
  int m_beats[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_owner[d] = 0; m_last[d] = 4; m_beats[d] = 0;
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (!m_busy[d]) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          int c;
          c = (m_last[d] + k) % NUM_SRC;
          if (req[c]) begin
            m_busy[d] = 1'b1; m_owner[d] = c; m_beats[d] = 0;
            break;
          end
        end
      end else if (!req[m_owner[d]]) begin
        m_busy[d] = 1'b0; m_last[d] = m_owner[d];
      end else if (out_ready) begin
        m_beats[d]++;
        if (m_beats[d] == burst[d]) begin
          m_busy[d] = 1'b0; m_last[d] = m_owner[d];
        end
      end
    end
  endtask

  task automatic model_out(input int d, output logic [2:0] s, output logic v, output logic [4:0] a);
    s = 3'(m_owner[d]);
    v = m_busy[d] && req[m_owner[d]];
    a = (v && out_ready) ? 5'(1 << m_owner[d]) : 5'b0;
  endtask

  task automatic get_out(input int d, output logic [2:0] s, output logic v, output logic [4:0] a);
    if (d == 0) begin s = sel4; v = ov4; a = ack4; end
    else        begin s = sel1; v = ov1; a = ack1; end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_models();
    logic [2:0] s, es;
    logic       v, ev;
    logic [4:0] a, ea;
    for (int d = 0; d < 2; d++) begin
      get_out(d, s, v, a);
      model_out(d, es, ev, ea);
      chk($sformatf("mdl%0d_sel", d), s, es);
      chk($sformatf("mdl%0d_valid", d), v, ev);
      chk($sformatf("mdl%0d_ack", d), a, ea);
      chk($sformatf("mdl%0d_sel_range", d), (s > SEL_E), 1'b0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] r, input logic rd);
    req = r;
    out_ready = rd;
    #1;
  endtask

  task automatic advance();
    if (rst) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 5'b11111;
    out_ready = 1'b1;
    #1;
    model_reset();
    check_models();
    chk("rst_state", st4, IDLE);
    chk("rst_ptr", ptr4, 3'd4);
    chk("rst_cnt", cnt4, 8'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         do_rst;
    logic [4:0] req;
    logic       rdy;
    int         dut;
    logic [2:0] sel;
    logic       valid;
    logic [4:0] ack;
  } vec_t;

  vec_t vec_q[$];

  function automatic vec_t mk(bit r0, logic [4:0] rq, logic rd, int d, logic [2:0] s, logic v, logic [4:0] a);
    vec_t t;
    t.do_rst = r0; t.req = rq; t.rdy = rd; t.dut = d; t.sel = s; t.valid = v; t.ack = a;
    return t;
  endfunction

  initial begin
    logic [2:0] s;
    logic       v;
    logic [4:0] a;
    logic [4:0] r;
    logic       rd;

    // Single requester a, burst 4: one arbitration cycle, 4 acks, one bubble, re-grant.
    vec_q.push_back(mk(1, 5'b00001, 1, 0, 3'd0, 0, 5'b00000));
    for (int i = 0; i < 4; i++) vec_q.push_back(mk(0, 5'b00001, 1, 0, 3'd0, 1, 5'b00001));
    vec_q.push_back(mk(0, 5'b00001, 1, 0, 3'd0, 0, 5'b00000));
    vec_q.push_back(mk(0, 5'b00001, 1, 0, 3'd0, 1, 5'b00001));
    // All requesting, burst 1: a,b,c,d,e,a with an idle bubble between grants.
    vec_q.push_back(mk(1, 5'b11111, 1, 1, 3'd0, 0, 5'b00000));
    for (int i = 0; i < 6; i++) begin
      vec_q.push_back(mk(0, 5'b11111, 1, 1, 3'(i % 5), 1, 5'(1 << (i % 5))));
      if (i < 5) vec_q.push_back(mk(0, 5'b11111, 1, 1, 3'(i % 5), 0, 5'b00000));
    end

    #2;
    foreach (vec_q[i]) begin
      if (vec_q[i].do_rst) do_reset();
      drive(vec_q[i].req, vec_q[i].rdy);
      check_models();
      get_out(vec_q[i].dut, s, v, a);
      chk($sformatf("tbl%0d_sel", i), s, vec_q[i].sel);
      chk($sformatf("tbl%0d_valid", i), v, vec_q[i].valid);
      chk($sformatf("tbl%0d_ack", i), a, vec_q[i].ack);
      advance();
    end

    // Stall on c: after one beat, hold out_ready low; sel, valid and cnt stay put.
    do_reset();
    drive(5'b00100, 1); check_models(); advance();
    drive(5'b00100, 1); check_models();
    chk("stall_first_ack", ack4, 5'b00100); advance();
    for (int i = 0; i < 5; i++) begin
      drive(5'b00100, 0); check_models();
      chk("stall_sel", sel4, 3'd2);
      chk("stall_valid", ov4, 1'b1);
      chk("stall_ack", ack4, 5'b0);
      chk("stall_cnt", cnt4, 8'd1);
      advance();
    end
    drive(5'b00100, 1); check_models();
    chk("stall_release_ack", ack4, 5'b00100); advance();

    // Wrap e -> a on the burst-1 instance, starting from ptr = d.
    do_reset();
    drive(5'b01000, 1); check_models(); advance();
    drive(5'b01000, 1); check_models();
    chk("wrap_d_sel", sel1, 3'd3);
    chk("wrap_d_ack", ack1, 5'b01000); advance();
    drive(5'b10001, 1); check_models();
    chk("wrap_ptr_d", ptr1, 3'd3);
    chk("wrap_idle", st1, IDLE); advance();
    drive(5'b10001, 1); check_models();
    chk("wrap_e_sel", sel1, 3'd4);
    chk("wrap_e_ack", ack1, 5'b10000); advance();
    drive(5'b00001, 1); check_models(); advance();
    drive(5'b00001, 1); check_models();
    chk("wrap_a_sel", sel1, 3'd0);
    chk("wrap_a_valid", ov1, 1'b1); advance();

    // b drops its request after two beats; release then pick c.
    do_reset();
    drive(5'b00010, 1); check_models(); advance();
    for (int i = 0; i < 2; i++) begin
      drive(5'b00010, 1); check_models();
      chk("drop_b_ack", ack4, 5'b00010); advance();
    end
    drive(5'b00100, 1); check_models();
    chk("drop_valid", ov4, 1'b0);
    chk("drop_ack", ack4, 5'b0); advance();
    drive(5'b00110, 1); check_models();
    chk("drop_idle", st4, IDLE);
    chk("drop_ptr", ptr4, 3'd1); advance();
    drive(5'b00110, 1); check_models();
    chk("drop_next_sel", sel4, 3'd2);
    chk("drop_next_valid", ov4, 1'b1); advance();

    // Asynchronous reset in the middle of a burst on d.
    do_reset();
    drive(5'b01000, 1); check_models(); advance();
    drive(5'b01000, 1); check_models();
    chk("mid_d_sel", sel4, 3'd3);
    chk("mid_d_ack", ack4, 5'b01000); advance();
    drive(5'b01000, 1); check_models();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_models();
    chk("mid_rst_sel", sel4, 3'd0);
    chk("mid_rst_valid", ov4, 1'b0);
    chk("mid_rst_ack", ack4, 5'b0);
    chk("mid_rst_state", st4, IDLE);
    chk("mid_rst_ptr", ptr4, 3'd4);
    @(negedge clk);
    rst = 1'b1;
    drive(5'b11000, 1); check_models(); advance();
    drive(5'b11000, 1); check_models();
    chk("post_rst_sel", sel4, 3'd3);
    chk("post_rst_valid", ov4, 1'b1); advance();

    // Randomized traffic against the model; requests mostly persist between cycles.
    do_reset();
    r = 5'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) != 0);
      drive(r, rd);
      check_models();
      advance();
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
